cond_exec_ctrl: RTL and testbench

- Condition-execution controller for the ID stage of the ARM-subset pipeline.
- Owns the NZCV status register and evaluates each ID instruction's 4-bit condition field against it.
- Schedules around flag hazards: stalls a conditional instruction while an older flag-setting instruction is still in EXE.
- Issues branch-taken and IF/ID flush control.

---
 rtl/cond_exec_ctrl_if.sv | 25 ++
 rtl/cond_exec_ctrl.sv | 129 ++++++++++++
 tb/tb_cond_exec_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_exec_ctrl_if.sv
// rtl/cond_exec_ctrl_if.sv - ID-stage condition/flag control bundle
// master = pipeline side driving instruction/flag info, slave = cond_exec_ctrl
interface cond_exec_ctrl_if;
  logic       pipe_freeze;
  logic       id_valid;
  logic [3:0] id_cond;
  logic       id_s;
  logic       id_branch;
  logic [3:0] exe_nzcv;
  logic       id_stall;
  logic       id_exec;
  logic       branch_taken;
  logic       if_flush;
  logic [3:0] status_nzcv;

  modport master (
    output pipe_freeze, id_valid, id_cond, id_s, id_branch, exe_nzcv,
    input  id_stall, id_exec, branch_taken, if_flush, status_nzcv
  );

  modport slave (
    input  pipe_freeze, id_valid, id_cond, id_s, id_branch, exe_nzcv,
    output id_stall, id_exec, branch_taken, if_flush, status_nzcv
  );
endinterface

// File: rtl/cond_exec_ctrl.sv
// rtl/cond_exec_ctrl.sv - NZCV owner, condition evaluation, flag-hazard stall and branch flush
// Optional COND_FWD_EN: forward EXE flags to ID instead of stalling on a flag hazard.
module cond_exec_ctrl #(
  parameter int FLUSH_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  cond_exec_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN = 2'd0, HAZ = 2'd1, FLUSH = 2'd2} state_t;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [2:0] flush_cnt, flush_cnt_nxt;
  logic [3:0] sr;
  logic       exe_s_q;
  logic [3:0] flags;
  logic       n_f, z_f, c_f, v_f;
  logic       cond_pass;
  logic       haz;
  logic       exec_c, stall_c, taken_c, flush_c;

`ifdef COND_FWD_EN
  assign flags = exe_s_q ? bus.exe_nzcv : sr;
  assign haz   = 1'b0;
`else
  assign flags = sr;
  assign haz   = bus.id_valid & exe_s_q & (bus.id_cond != 4'b1110);
`endif

  assign {n_f, z_f, c_f, v_f} = flags;

  always_comb begin
    case (bus.id_cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = c_f & ~z_f;
      4'b1001: cond_pass = ~c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= 3'd0;
    end else if (!bus.pipe_freeze) begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // SR takes the flags of whichever instruction was in EXE during this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr      <= 4'b0000;
      exe_s_q <= 1'b0;
    end else if (!bus.pipe_freeze) begin
      exe_s_q <= exec_c & bus.id_s;
      if (exe_s_q) begin
        sr <= bus.exe_nzcv;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      RUN, HAZ: begin
        if (state == RUN && haz) begin
          state_nxt = HAZ;
        end else if (taken_c && FLUSH_CYCLES > 1) begin
          state_nxt     = FLUSH;
          flush_cnt_nxt = FLUSH_LOAD;
        end else begin
          state_nxt = RUN;
        end
      end
      FLUSH: begin
        // flush_cnt counts the FLUSH cycles still to go, including this one
        flush_cnt_nxt = flush_cnt - 3'd1;
        if (flush_cnt <= 3'd1) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    exec_c  = 1'b0;
    stall_c = 1'b0;
    taken_c = 1'b0;
    flush_c = 1'b0;
    case (state)
      FLUSH: flush_c = 1'b1;
      default: begin
        if (state == RUN && haz) begin
          stall_c = 1'b1;
        end else begin
          exec_c  = bus.id_valid & cond_pass;
          taken_c = exec_c & bus.id_branch;
          flush_c = taken_c;
        end
      end
    endcase
  end

  assign bus.id_exec      = ~rst & exec_c;
  assign bus.id_stall     = ~rst & (stall_c | bus.pipe_freeze);
  assign bus.branch_taken = ~rst & taken_c;
  assign bus.if_flush     = ~rst & flush_c;
  assign bus.status_nzcv  = sr;

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// tb/tb_cond_exec_ctrl.sv - randomized and directed bench for cond_exec_ctrl against a flag/flush model
module tb_cond_exec_ctrl;

  localparam int FC = 3;
`ifdef COND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  cond_exec_ctrl_if bus ();

  cond_exec_ctrl #(.FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // model: architectural flags, whether a flag writer sits in EXE, flush cycles still owed
  logic [3:0] m_sr;
  bit         m_wr;
  int         m_flush_left;
  bit         e_exec, e_stall, e_taken, e_flush;

  function automatic bit cpass(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v, r;
    {n, z, c, v} = f;
    case (cond[3:1])
      3'd0: r = z;
      3'd1: r = c;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = c && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (cond == 4'hF) return 1'b0;
    return cond[0] ? !r : r;
  endfunction

  task automatic model_reset();
    m_sr = 4'b0000;
    m_wr = 1'b0;
    m_flush_left = 0;
  endtask

  // entered at posedge+1; leaves at the following negedge with e_* set
  task automatic apply(input bit v, input logic [3:0] cond, input bit s, input bit br,
                       input logic [3:0] nz, input bit frz);
    bus.id_valid = v; bus.id_cond = cond; bus.id_s = s; bus.id_branch = br;
    bus.exe_nzcv = nz; bus.pipe_freeze = frz;
    e_exec = 0; e_stall = 0; e_taken = 0; e_flush = 0;
    if (m_flush_left > 0) begin
      e_flush = 1;
    end else if (!FWD && v && m_wr && cond != 4'hE) begin
      e_stall = 1;
    end else begin
      e_exec  = v && cpass(cond, (FWD && m_wr) ? nz : m_sr);
      e_taken = e_exec && br;
      e_flush = e_taken;
    end
    if (frz) e_stall = 1;
    #4;
  endtask

  task automatic tick();
    logic [3:0] nz;
    bit frz, s;
    nz = bus.exe_nzcv; frz = bus.pipe_freeze; s = bus.id_s;
    @(posedge clk);
    if (!frz) begin
      if (m_wr) m_sr = nz;
      m_wr = e_exec && s;
      if (m_flush_left > 0) m_flush_left--;
      else if (e_taken) m_flush_left = FC - 1;
    end
    #1;
  endtask

  task automatic load_sr(input logic [3:0] f);
    apply(1, 4'hE, 1, 0, f, 0); tick();
    apply(0, 4'hE, 0, 0, f, 0); tick();
  endtask

  task automatic test_reset();
    load_sr(4'hF);
    apply(1, 4'hE, 0, 1, 4'h0, 0);
    checks++; if (bus.branch_taken !== 1'b1) begin errors++; $display("FAIL reset_pre_branch got %b want 1", bus.branch_taken); end
    tick();
    apply(1, 4'hE, 0, 0, 4'h0, 0);
    checks++; if (bus.if_flush !== 1'b1) begin errors++; $display("FAIL reset_pre_flush got %b want 1", bus.if_flush); end
    rst = 1'b1; bus.exe_nzcv = 4'hA;
    #1;
    checks++;
    if ({bus.id_stall, bus.id_exec, bus.branch_taken, bus.if_flush} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b want 0000", {bus.id_stall, bus.id_exec, bus.branch_taken, bus.if_flush});
    end
    checks++; if (bus.status_nzcv !== 4'b0000) begin errors++; $display("FAIL reset_status got %b want 0000", bus.status_nzcv); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    apply(1, 4'hE, 0, 0, 4'h0, 0);
    checks++; if (bus.id_exec !== 1'b1) begin errors++; $display("FAIL reset_first_al got %b want 1", bus.id_exec); end
    checks++; if (bus.if_flush !== 1'b0) begin errors++; $display("FAIL reset_no_flush got %b want 0", bus.if_flush); end
    checks++; if (bus.status_nzcv !== 4'b0000) begin errors++; $display("FAIL reset_status_after got %b want 0000", bus.status_nzcv); end
    tick();
  endtask

  task automatic test_hazard();
    apply(1, 4'hE, 1, 0, 4'h0, 0);
    checks++; if (bus.id_exec !== 1'b1) begin errors++; $display("FAIL hazard_writer got %b want 1", bus.id_exec); end
    tick();
    apply(1, 4'h0, 0, 0, 4'b0100, 0);
    checks++; if (bus.id_stall !== !FWD) begin errors++; $display("FAIL hazard_stall got %b want %b", bus.id_stall, !FWD); end
    checks++; if (bus.id_exec !== FWD) begin errors++; $display("FAIL hazard_exec got %b want %b", bus.id_exec, FWD); end
    tick();
    checks++; if (bus.status_nzcv !== 4'b0100) begin errors++; $display("FAIL hazard_sr got %b want 0100", bus.status_nzcv); end
    if (!FWD) begin
      apply(1, 4'h0, 0, 0, 4'b0000, 0);
      checks++; if ({bus.id_stall, bus.id_exec} !== 2'b01) begin errors++; $display("FAIL hazard_after got %b want 01", {bus.id_stall, bus.id_exec}); end
      tick();
    end
  endtask

  task automatic test_cond_table();
    for (int f = 0; f < 16; f++) begin
      load_sr(4'(f));
      for (int c = 0; c < 16; c++) begin
        apply(1, 4'(c), 0, 0, 4'($urandom), 0);
        checks++;
        if ({bus.id_stall, bus.id_exec} !== {1'b0, e_exec}) begin
          errors++; $display("FAIL cond_table f=%b c=%b got %b want %b", 4'(f), 4'(c), {bus.id_stall, bus.id_exec}, {1'b0, e_exec});
        end
        if (f == 4'b0110 && c == 9) begin
          checks++; if (bus.id_exec !== 1'b1) begin errors++; $display("FAIL cond_ls_cz got %b want 1", bus.id_exec); end
        end
        if (f == 4'b0100 && c == 12) begin
          checks++; if (bus.id_exec !== 1'b0) begin errors++; $display("FAIL cond_gt_z got %b want 0", bus.id_exec); end
        end
        tick();
      end
    end
  endtask

  task automatic test_branch_flush();
    load_sr(4'b0100);
    apply(1, 4'h0, 0, 1, 4'h0, 0);
    checks++;
    if ({bus.branch_taken, bus.if_flush, bus.id_exec} !== 3'b111) begin
      errors++; $display("FAIL branch_cycle got %b want 111", {bus.branch_taken, bus.if_flush, bus.id_exec});
    end
    tick();
    for (int k = 0; k < FC - 1; k++) begin
      apply(1, 4'hE, 0, 0, 4'h0, 0);
      checks++;
      if ({bus.branch_taken, bus.if_flush, bus.id_exec, bus.id_stall} !== 4'b0100) begin
        errors++; $display("FAIL branch_flush%0d got %b want 0100", k, {bus.branch_taken, bus.if_flush, bus.id_exec, bus.id_stall});
      end
      tick();
    end
    apply(1, 4'hE, 0, 0, 4'h0, 0);
    checks++;
    if ({bus.if_flush, bus.id_exec} !== 2'b01) begin
      errors++; $display("FAIL branch_resume got %b want 01", {bus.if_flush, bus.id_exec});
    end
    tick();
  endtask

  task automatic test_freeze();
    load_sr(4'b0000);
    apply(1, 4'hE, 1, 0, 4'b1010, 0); tick();
    for (int i = 0; i < 4; i++) begin
      apply(1, 4'hE, 0, 0, 4'($urandom_range(1, 15)), 1);
      checks++; if (bus.id_stall !== 1'b1) begin errors++; $display("FAIL freeze_stall%0d got %b want 1", i, bus.id_stall); end
      checks++; if (bus.status_nzcv !== 4'b0000) begin errors++; $display("FAIL freeze_sr%0d got %b want 0000", i, bus.status_nzcv); end
      tick();
    end
    apply(0, 4'hE, 0, 0, 4'b1001, 0);
    checks++; if (bus.status_nzcv !== 4'b0000) begin errors++; $display("FAIL freeze_release_pre got %b want 0000", bus.status_nzcv); end
    tick();
    checks++; if (bus.status_nzcv !== 4'b1001) begin errors++; $display("FAIL freeze_release got %b want 1001", bus.status_nzcv); end
  endtask

  task automatic test_failed_s();
    load_sr(4'b0100);
    apply(1, 4'h1, 1, 0, 4'b0000, 0);
    checks++; if (bus.id_exec !== 1'b0) begin errors++; $display("FAIL failed_s_exec got %b want 0", bus.id_exec); end
    tick();
    apply(1, 4'h0, 0, 0, 4'b0000, 0);
    checks++; if ({bus.id_stall, bus.id_exec} !== 2'b01) begin errors++; $display("FAIL failed_s_next got %b want 01", {bus.id_stall, bus.id_exec}); end
    tick();
    checks++; if (bus.status_nzcv !== 4'b0100) begin errors++; $display("FAIL failed_s_sr got %b want 0100", bus.status_nzcv); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      apply(($urandom % 4) != 0, 4'($urandom), 1'($urandom), ($urandom % 4) == 0,
            4'($urandom), ($urandom % 8) == 0);
      checks++;
      if ({bus.id_stall, bus.id_exec, bus.branch_taken, bus.if_flush} !== {e_stall, e_exec, e_taken, e_flush}) begin
        errors++; $display("FAIL random%0d ctrl got %b want %b", i,
          {bus.id_stall, bus.id_exec, bus.branch_taken, bus.if_flush}, {e_stall, e_exec, e_taken, e_flush});
      end
      checks++;
      if (bus.status_nzcv !== m_sr) begin
        errors++; $display("FAIL random%0d sr got %b want %b", i, bus.status_nzcv, m_sr);
      end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.pipe_freeze = 0; bus.id_valid = 0; bus.id_cond = 4'h0;
    bus.id_s = 0; bus.id_branch = 0; bus.exe_nzcv = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_hazard();
    test_cond_table();
    test_branch_flush();
    test_freeze();
    test_failed_s();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
